// File: rtl/data_mem_init.sv
// ---------------------------------------------------------------------------
// data_mem_init
//   Parametrised data memory that sits between the core's load/store unit and
//   the top level. It has one combinational read port and one synchronous
//   write port. After reset a sequencer clears every entry to CLR_VAL and
//   then writes a fixed constant table. Ready tells the core that the memory
//   may be used.
//
//   Optional build macro: DMEM_PARITY_EN
//     When defined, each entry also stores an even-parity bit. ParityErr then
//     flags a parity mismatch on the entry at RdAddr.
//     When undefined, ParityErr is tied to 0.
//     The port list is the same in both builds.
//
// Parameters
//   W        data width per entry
//   A        address width (depth = 2**A)
//   CLR_VAL  value written to every entry by the clear sweep
//
// Ports
//   Clk        clock; all writes happen on the rising edge
//   Reset      asynchronous, active-high reset
//   WriteEn    store request; ignored until Ready
//   WrAddr     write address
//   DataIn     write data
//   RdAddr     read address
//   DataOut    read data (combinational, 0 while not Ready)
//   Ready      high once initialisation is complete
//   ParityErr  parity mismatch on the current read (0 while not Ready)
// ---------------------------------------------------------------------------
module data_mem_init #(
  parameter int           W       = 8,
  parameter int           A       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] WrAddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RdAddr,
  output logic [W-1:0] DataOut,
  output logic         Ready,
  output logic         ParityErr
);

  localparam int DEPTH = 2 ** A;
  localparam int NPRE  = 12;
`ifdef DMEM_PARITY_EN
  localparam int MW = W + 1;
`else
  localparam int MW = W;
`endif

  typedef enum logic [1:0] {CLEAR, PRELOAD, RUN} state_t;

  state_t       state_q, state_d;
  logic [A:0]   cnt_q, cnt_d;     // one extra bit so the carry out marks the end of the sweep
  logic [3:0]   idx_q, idx_d;
  logic         ready_q, ready_d;

  // Constant preload table, applied in index order
  function automatic logic [31:0] pre_addr(input logic [3:0] i);
    case (i)
      4'd0:  pre_addr = 32'd52;
      4'd1:  pre_addr = 32'd53;
      4'd2:  pre_addr = 32'd54;
      4'd3:  pre_addr = 32'd55;
      4'd4:  pre_addr = 32'd56;
      4'd5:  pre_addr = 32'd57;
      4'd6:  pre_addr = 32'd58;
      4'd7:  pre_addr = 32'd59;
      4'd8:  pre_addr = 32'd60;
      4'd9:  pre_addr = 32'd128;
      4'd10: pre_addr = 32'd129;
      4'd11: pre_addr = 32'd130;
      default: pre_addr = 32'd0;
    endcase
  endfunction

  function automatic logic [7:0] pre_val(input logic [3:0] i);
    case (i)
      4'd0:  pre_val = 8'h60;
      4'd1:  pre_val = 8'h48;
      4'd2:  pre_val = 8'h78;
      4'd3:  pre_val = 8'h72;
      4'd4:  pre_val = 8'h6A;
      4'd5:  pre_val = 8'h69;
      4'd6:  pre_val = 8'h5C;
      4'd7:  pre_val = 8'h7E;
      4'd8:  pre_val = 8'h7B;
      4'd9:  pre_val = 8'h01;
      4'd10: pre_val = 8'hFF;
      4'd11: pre_val = 8'h40;
      default: pre_val = 8'h00;
    endcase
  endfunction

  logic [31:0]  pa;
  logic [7:0]   pv;
  assign pa = pre_addr(idx_q);
  assign pv = pre_val(idx_q);

  // Write-port arbitration: the sequencer owns the port until RUN
  logic         we;
  logic [A-1:0] waddr;
  logic [W-1:0] wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q[A-1:0];
        wdata = CLR_VAL;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d[A]) begin
          state_d = PRELOAD;
          idx_d   = '0;
        end
      end
      PRELOAD: begin
        // Out-of-range table entries still use up their cycle
        we    = (pa < 32'(DEPTH));
        waddr = pa[A-1:0];
        wdata = W'(pv);
        idx_d = idx_q + 1'b1;
        if (idx_q == 4'(NPRE - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        we    = WriteEn;
        waddr = WrAddr;
        wdata = DataIn;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Storage: contents are not reset; the sequencer rebuilds them
  logic [MW-1:0] mem_q [DEPTH];
  logic [MW-1:0] wentry;
  logic [MW-1:0] rentry;

`ifdef DMEM_PARITY_EN
  assign wentry = {^wdata, wdata};  // even parity over the whole stored word
`else
  assign wentry = wdata;
`endif

  always_ff @(posedge Clk) begin
    if (we && !Reset) mem_q[waddr] <= wentry;
  end

  assign rentry  = mem_q[RdAddr];
  assign Ready   = ready_q;
  assign DataOut = ready_q ? rentry[W-1:0] : '0;

`ifdef DMEM_PARITY_EN
  assign ParityErr = ready_q & (^rentry);
`else
  assign ParityErr = 1'b0;
`endif

endmodule
